// File: rtl/seg_frame_decoder.sv
// Monitors the active-low anode/cathode lines of a multiplexed 4-digit 7-segment display,
// rebuilds each displayed frame and reports it as packed BCD and as binary.
module seg_frame_decoder #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  anode,
    input  logic [6:0]  cathode,
    output logic [15:0] value_bcd,
    output logic [13:0] value_bin,
    output logic        pattern_err,
    output logic        frame_valid,
    output logic        busy
);

    typedef enum logic [1:0] {COLLECT, CONVERT, DONE} state_t;

    state_t      state;
    logic [3:0]  prev_anode;
    logic [6:0]  prev_cathode;
    logic [7:0]  stab_cnt;
    logic        armed;
    logic [3:0]  seen;
    logic [15:0] dig_q;
    logic [3:0]  err_q;
    logic [15:0] work_bcd;
    logic        work_err;
    logic [13:0] acc;
    logic [1:0]  step;

    logic        slot_legal;
    logic [1:0]  slot_idx;
    logic [7:0]  run_len;
    logic        capture;
    logic [4:0]  dec;
    logic [15:0] dig_next;
    logic [3:0]  err_next;
    logic [3:0]  seen_next;
    logic [3:0]  cur_digit;
    logic [13:0] acc_next;

    // Returns {error, digit}; unknown patterns decode as digit 0 with the error bit set.
    function automatic logic [4:0] decode(input logic [6:0] c);
        case (c)
            7'b1000000: decode = 5'h00;
            7'b1111001: decode = 5'h01;
            7'b0100100: decode = 5'h02;
            7'b0110000: decode = 5'h03;
            7'b0011001: decode = 5'h04;
            7'b0010010: decode = 5'h05;
            7'b0000010: decode = 5'h06;
            7'b1111000: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0010000: decode = 5'h09;
            default:    decode = 5'h10;
        endcase
    endfunction

    always_comb begin
        slot_legal = 1'b1;
        slot_idx   = 2'd0;
        case (anode)
            4'b1110: slot_idx = 2'd0;
            4'b1101: slot_idx = 2'd1;
            4'b1011: slot_idx = 2'd2;
            4'b0111: slot_idx = 2'd3;
            default: slot_legal = 1'b0;
        endcase
    end

    // run_len counts the current cycle, so a capture lands on the SETTLE_CYCLES-th identical cycle.
    always_comb begin
        if ({anode, cathode} != {prev_anode, prev_cathode})
            run_len = 8'd1;
        else if (stab_cnt == 8'hFF)
            run_len = 8'hFF;
        else
            run_len = stab_cnt + 8'd1;
    end

    assign capture   = slot_legal && (armed || (anode != prev_anode))
                       && (run_len == 8'(SETTLE_CYCLES));
    assign dec       = decode(cathode);
    assign seen_next = seen | (4'b0001 << slot_idx);

    always_comb begin
        dig_next = dig_q;
        err_next = err_q;
        dig_next[{slot_idx, 2'b00} +: 4] = dec[3:0];
        err_next[slot_idx] = dec[4];
    end

    always_comb begin
        case (step)
            2'd0:    cur_digit = work_bcd[15:12];
            2'd1:    cur_digit = work_bcd[11:8];
            2'd2:    cur_digit = work_bcd[7:4];
            default: cur_digit = work_bcd[3:0];
        endcase
    end

    assign acc_next = (acc << 3) + (acc << 1) + {10'd0, cur_digit};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= COLLECT;
            prev_anode   <= 4'd0;
            prev_cathode <= 7'd0;
            stab_cnt     <= 8'd0;
            armed        <= 1'b0;
            seen         <= 4'd0;
            dig_q        <= 16'd0;
            err_q        <= 4'd0;
            work_bcd     <= 16'd0;
            work_err     <= 1'b0;
            acc          <= 14'd0;
            step         <= 2'd0;
            value_bcd    <= 16'd0;
            value_bin    <= 14'd0;
            pattern_err  <= 1'b0;
            frame_valid  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            prev_anode   <= anode;
            prev_cathode <= cathode;
            stab_cnt     <= slot_legal ? run_len : 8'd0;
            if (capture)
                armed <= 1'b0;
            else if (anode != prev_anode)
                armed <= 1'b1;
            frame_valid <= 1'b0;

            case (state)
                COLLECT: begin
                    if (capture) begin
                        dig_q <= dig_next;
                        err_q <= err_next;
                        if (seen_next == 4'hF) begin
                            seen     <= 4'd0;
                            work_bcd <= dig_next;
                            work_err <= |err_next;
                            acc      <= 14'd0;
                            step     <= 2'd0;
                            busy     <= 1'b1;
                            state    <= CONVERT;
                        end else begin
                            seen <= seen_next;
                        end
                    end
                end
                CONVERT: begin
                    acc  <= acc_next;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        value_bin   <= acc_next;
                        value_bcd   <= work_bcd;
                        pattern_err <= work_err;
                        frame_valid <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE:    state <= COLLECT;
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Bench for seg_frame_decoder: table-driven frame scans plus hand-written corner sequences,
// with a scoreboard that checks every frame_valid against a queued expectation and its cycle.
module tb_seg_frame_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic [15:0] value_bcd;
    logic [13:0] value_bin;
    logic        pattern_err;
    logic        frame_valid;
    logic        busy;

    seg_frame_decoder #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .anode(anode), .cathode(cathode),
        .value_bcd(value_bcd), .value_bin(value_bin), .pattern_err(pattern_err),
        .frame_valid(frame_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [15:0] cyc = 16'd0;
    always @(posedge clk) cyc <= cyc + 16'd1;

    // Entry: {expected cycle[46:31], bcd[30:15], bin[14:1], err[0]}
    logic [46:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int fv_count = 0;

    typedef struct {
        logic [6:0]  c0, c1, c2, c3;
        logic [15:0] bcd;
        logic [13:0] bin;
        logic        err;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (frame_valid) begin
            logic [46:0] e;
            fv_count++;
            if (exp_q.size() == 0) begin
                check("frame_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("frame_cycle", 32'(cyc), 32'(e[46:31]));
                check("value_bcd", 32'(value_bcd), 32'(e[30:15]));
                check("value_bin", 32'(value_bin), 32'(e[14:1]));
                check("pattern_err", 32'(pattern_err), 32'(e[0]));
            end
        end
    end

    task automatic drive_raw(input logic [3:0] a, input logic [6:0] c, input int hold);
        anode   = a;
        cathode = c;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scan(input logic [6:0] c0, c1, c2, c3, input int hold, input int gap,
                        input bit push, input logic [30:0] exp_out);
        drive_raw(4'b1110, c0, hold);
        drive_raw(4'hF, 7'h7F, gap);
        drive_raw(4'b1101, c1, hold);
        drive_raw(4'hF, 7'h7F, gap);
        drive_raw(4'b1011, c2, hold);
        drive_raw(4'hF, 7'h7F, gap);
        if (push) exp_q.push_back({cyc + 16'd8, exp_out});
        drive_raw(4'b0111, c3, hold);
        drive_raw(4'hF, 7'h7F, gap);
    endtask

    initial begin
        vecs[0] = '{c0: 7'h79, c1: 7'h24, c2: 7'h30, c3: 7'h19, bcd: 16'h4321, bin: 14'd4321, err: 1'b0};
        vecs[1] = '{c0: 7'h10, c1: 7'h10, c2: 7'h10, c3: 7'h10, bcd: 16'h9999, bin: 14'd9999, err: 1'b0};
        vecs[2] = '{c0: 7'h40, c1: 7'h40, c2: 7'h40, c3: 7'h40, bcd: 16'h0000, bin: 14'd0,    err: 1'b0};
        vecs[3] = '{c0: 7'h00, c1: 7'h7F, c2: 7'h02, c3: 7'h12, bcd: 16'h5608, bin: 14'd5608, err: 1'b1};
        vecs[4] = '{c0: 7'h78, c1: 7'h10, c2: 7'h40, c3: 7'h79, bcd: 16'h1097, bin: 14'd1097, err: 1'b0};

        rst_n   = 1'b0;
        anode   = 4'hF;
        cathode = 7'h7F;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_bcd", 32'(value_bcd), 32'd0);
        check("reset_bin", 32'(value_bin), 32'd0);
        check("reset_err", 32'(pattern_err), 32'd0);
        check("reset_valid", 32'(frame_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_raw(4'hF, 7'h7F, 2);

        // Odd entries put a blank slot between digits.
        for (int i = 0; i < 5; i++) begin
            scan(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3, 8, (i % 2) * 2, 1'b1,
                 {vecs[i].bcd, vecs[i].bin, vecs[i].err});
        end
        drive_raw(4'hF, 7'h7F, 10);
        check("frames_after_table", 32'(fv_count), 32'd5);

        // Slots held shorter than the settle time never capture.
        for (int r = 0; r < 2; r++) begin
            drive_raw(4'b1110, 7'h79, 3);
            drive_raw(4'hF, 7'h7F, 1);
            drive_raw(4'b1101, 7'h24, 3);
            drive_raw(4'b1011, 7'h30, 3);
            drive_raw(4'hF, 7'h7F, 1);
            drive_raw(4'b0111, 7'h19, 3);
        end
        drive_raw(4'hF, 7'h7F, 12);
        check("short_hold_no_frame", 32'(fv_count), 32'd5);

        // Two anodes low is ignored; revisiting ones with 7 overwrites the earlier 3.
        drive_raw(4'b1110, 7'h30, 8);
        drive_raw(4'b1100, 7'h00, 10);
        drive_raw(4'hF, 7'h7F, 2);
        drive_raw(4'b1101, 7'h24, 8);
        drive_raw(4'b1110, 7'h78, 8);
        drive_raw(4'b1011, 7'h12, 8);
        exp_q.push_back({cyc + 16'd8, 16'h1527, 14'd1527, 1'b0});
        drive_raw(4'b0111, 7'h79, 8);
        drive_raw(4'hF, 7'h7F, 6);
        check("frames_after_overwrite", 32'(fv_count), 32'd6);

        // Reset during the second CONVERT cycle aborts the frame.
        drive_raw(4'b1110, 7'h02, 8);
        drive_raw(4'b1101, 7'h02, 8);
        drive_raw(4'b1011, 7'h02, 8);
        drive_raw(4'b0111, 7'h02, 5);
        check("busy_in_convert", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_bcd", 32'(value_bcd), 32'd0);
        check("abort_bin", 32'(value_bin), 32'd0);
        check("abort_err", 32'(pattern_err), 32'd0);
        check("abort_valid", 32'(frame_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        drive_raw(4'hF, 7'h7F, 12);
        check("frames_after_abort", 32'(fv_count), 32'd6);

        scan(7'h79, 7'h24, 7'h30, 7'h19, 8, 0, 1'b1, {16'h4321, 14'd4321, 1'b0});
        drive_raw(4'hF, 7'h7F, 20);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("frame_count", 32'(fv_count), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
